// File: rtl/bk_mem_pkg.sv
// Shared types for the SRAM arbiter: access states, requester IDs and
// the video lead window.
package bk_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        WS,
        WP,
        WH
    } state_e;

    typedef enum logic [1:0] {
        RQ_NONE,
        RQ_VID,
        RQ_DBG,
        RQ_CPU
    } rq_e;

    localparam int VID_LEAD = 3;
    localparam int AW_DEF   = 18;

endpackage

// File: rtl/sram_arbiter_if.sv
// Pad-side bus of the external 16-bit asynchronous SRAM.
// master = arbiter, slave = pads / memory model.
interface sram_arbiter_if #(
    parameter int AW = 18
);
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_o;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_i;
    logic          sram_we_n;
    logic          sram_oe_n;
    logic          sram_lb_n;
    logic          sram_ub_n;

    modport master (
        output sram_addr, sram_dq_o, sram_dq_oe,
        output sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n,
        input  sram_dq_i
    );

    modport slave (
        input  sram_addr, sram_dq_o, sram_dq_oe,
        input  sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n,
        output sram_dq_i
    );
endinterface

// File: rtl/sram_io.sv
// Pad-facing output registers: every SRAM pin changes only on clk and
// falls back to the inactive level as soon as reset asserts.
module sram_io #(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] addr_d_i,
    input  logic [15:0]   dq_d_i,
    input  logic          dq_oe_d_i,
    input  logic          we_n_d_i,
    input  logic          oe_n_d_i,
    input  logic          lb_n_d_i,
    input  logic          ub_n_d_i,
    output logic [AW-1:0] addr_o,
    output logic [15:0]   dq_o,
    output logic          dq_oe_o,
    output logic          we_n_o,
    output logic          oe_n_o,
    output logic          lb_n_o,
    output logic          ub_n_o
);

    logic [AW-1:0] addr_q;
    logic [15:0]   dq_q;
    logic          dq_oe_q;
    logic          we_n_q;
    logic          oe_n_q;
    logic          lb_n_q;
    logic          ub_n_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            dq_q    <= '0;
            dq_oe_q <= 1'b0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
        end else begin
            addr_q  <= addr_d_i;
            dq_q    <= dq_d_i;
            dq_oe_q <= dq_oe_d_i;
            we_n_q  <= we_n_d_i;
            oe_n_q  <= oe_n_d_i;
            lb_n_q  <= lb_n_d_i;
            ub_n_q  <= ub_n_d_i;
        end
    end

    assign addr_o  = addr_q;
    assign dq_o    = dq_q;
    assign dq_oe_o = dq_oe_q;
    assign we_n_o  = we_n_q;
    assign oe_n_o  = oe_n_q;
    assign lb_n_o  = lb_n_q;
    assign ub_n_o  = ub_n_q;

endmodule

// File: rtl/sram_arbiter.sv
// Three-way SRAM arbiter (video > debug > CPU) with fixed read/write
// sequences, debug hold/hlda handshake and late-video latching.
module sram_arbiter
    import bk_mem_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [1:0]    cpu_be,
    input  logic [15:0]   cpu_wdata,
    output logic [15:0]   cpu_rdata,
    output logic          cpu_ack,

    input  logic          dbg_hold,
    output logic          dbg_hlda,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [15:0]   dbg_wdata,
    output logic [15:0]   dbg_rdata,
    output logic          dbg_ack,

    input  logic          vid_soon,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [15:0]   vid_data,
    output logic          vid_valid,
    output logic          vid_late,

    sram_arbiter_if.master sram
);

    state_e        state_q, state_d;
    rq_e           rq_q, rq_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [1:0]    be_q, be_d;

    logic          vpend_q, vpend_d;
    logic [AW-1:0] vaddr_q, vaddr_d;
    logic          late_q, late_d;
    logic          hlda_q, hlda_d;

    logic          cpu_ack_q, dbg_ack_q, vid_valid_q;
    logic [15:0]   cpu_rdata_q, dbg_rdata_q, vid_data_q;

    logic vid_go, dbg_go, cpu_go;
    logic rd_d, wr_d;
    logic done_rd, done_wr;

    // An ack cycle is the requester's turn to drop req, so it blocks regrant.
    assign vid_go = vid_req | vpend_q;
    assign dbg_go = dbg_req & dbg_hold & hlda_q & ~vid_soon & ~dbg_ack_q;
    assign cpu_go = cpu_req & ~dbg_hold & ~hlda_q & ~vid_soon & ~cpu_ack_q;

    always_comb begin
        state_d = state_q;
        rq_d    = rq_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        if (state_q == IDLE) begin
            if (vid_go) begin
                rq_d    = RQ_VID;
                we_d    = 1'b0;
                addr_d  = vid_req ? vid_addr : vaddr_q;
                be_d    = 2'b11;
                state_d = RD1;
            end else if (dbg_go) begin
                rq_d    = RQ_DBG;
                we_d    = dbg_we;
                addr_d  = dbg_addr;
                wdata_d = dbg_wdata;
                be_d    = 2'b11;
                state_d = dbg_we ? WS : RD1;
            end else if (cpu_go) begin
                rq_d    = RQ_CPU;
                we_d    = cpu_we;
                addr_d  = cpu_addr;
                wdata_d = cpu_wdata;
                be_d    = cpu_be;
                state_d = cpu_we ? WS : RD1;
            end else begin
                rq_d = RQ_NONE;
            end
        end else begin
            unique case (state_q)
                RD1:     state_d = RD2;
                RD2:     state_d = IDLE;
                WS:      state_d = WP;
                WP:      state_d = WH;
                WH:      state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        vpend_d = vpend_q;
        vaddr_d = vaddr_q;
        late_d  = late_q;
        hlda_d  = hlda_q;
        if (state_q != IDLE) begin
            if (vid_req) begin
                vpend_d = 1'b1;
                vaddr_d = vid_addr;
                late_d  = 1'b1;
            end
        end else begin
            vpend_d = 1'b0;
            hlda_d  = dbg_hold;
        end
    end

    assign rd_d = (state_d == RD1) || (state_d == RD2);
    assign wr_d = (state_d == WS) || (state_d == WP) || (state_d == WH);

    assign done_rd = (state_q == RD2);
    assign done_wr = (state_q == WH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rq_q        <= RQ_NONE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            vpend_q     <= 1'b0;
            vaddr_q     <= '0;
            late_q      <= 1'b0;
            hlda_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            vid_valid_q <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            vid_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rq_q        <= rq_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            vpend_q     <= vpend_d;
            vaddr_q     <= vaddr_d;
            late_q      <= late_d;
            hlda_q      <= hlda_d;
            cpu_ack_q   <= (done_rd | done_wr) && (rq_q == RQ_CPU);
            dbg_ack_q   <= (done_rd | done_wr) && (rq_q == RQ_DBG);
            vid_valid_q <= done_rd && (rq_q == RQ_VID);
            if (done_rd && rq_q == RQ_CPU) cpu_rdata_q <= sram.sram_dq_i;
            if (done_rd && rq_q == RQ_DBG) dbg_rdata_q <= sram.sram_dq_i;
            if (done_rd && rq_q == RQ_VID) vid_data_q  <= sram.sram_dq_i;
        end
    end

    sram_io #(
        .AW(AW)
    ) u_io (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr_d_i  (addr_d),
        .dq_d_i    (wdata_d),
        .dq_oe_d_i (wr_d),
        .we_n_d_i  (state_d != WP),
        .oe_n_d_i  (~rd_d),
        .lb_n_d_i  (rd_d ? 1'b0 : (wr_d ? ~be_d[0] : 1'b1)),
        .ub_n_d_i  (rd_d ? 1'b0 : (wr_d ? ~be_d[1] : 1'b1)),
        .addr_o    (sram.sram_addr),
        .dq_o      (sram.sram_dq_o),
        .dq_oe_o   (sram.sram_dq_oe),
        .we_n_o    (sram.sram_we_n),
        .oe_n_o    (sram.sram_oe_n),
        .lb_n_o    (sram.sram_lb_n),
        .ub_n_o    (sram.sram_ub_n)
    );

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dbg_rdata = dbg_rdata_q;
    assign dbg_ack   = dbg_ack_q;
    assign dbg_hlda  = hlda_q;
    assign vid_data  = vid_data_q;
    assign vid_valid = vid_valid_q;
    assign vid_late  = late_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single external 16-bit asynchronous SRAM among three requesters: the video fetch path (pixel shifter loads), the JTAG debug host, and the CPU core. It sequences every SRAM access through a fixed read or write state machine that drives registered pins. It also implements the debug hold/hold-acknowledge handshake. Video reads have guaranteed fixed latency when the sync generator honours the `vid_soon` lead window. The block sits between `bkcore`/`jtag_top`/`shifter` and the SRAM pads in the top level.

## Interface
- `VID_LEAD`, 3: minimum cycles `vid_soon` precedes `vid_req`. This equals the longest non-video access.
- `AW`, 18: SRAM word-address width.

Ports:
- `clk` in 1: single clock, 25 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU access request, level. Held until `cpu_ack`.
- `cpu_we` in 1: 1 = write.
- `cpu_addr` in AW: word address.
- `cpu_be` in 2: byte enables, active-high. [0] = low byte.
- `cpu_wdata` in 16: write data.
- `cpu_rdata` out 16: read data.
- `cpu_ack` out 1: one-cycle completion pulse.
- `dbg_hold` in 1: debug host requests the bus.
- `dbg_hlda` out 1: bus granted to debug; CPU is stalled.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_rdata`, `dbg_ack`: same meaning as the CPU set. Accesses are always full-word.
- `vid_soon` in 1: a video slot is imminent. Blocks new CPU/debug starts.
- `vid_req` in 1: one-cycle video read strobe.
- `vid_addr` in AW: video word address.
- `vid_data` out 16: video read data.
- `vid_valid` out 1: one-cycle pulse.
- `vid_late` out 1: sticky flag, set on a lead-window violation.
- `sram_addr` out AW: SRAM address.
- `sram_dq_o` out 16: write data to the pads.
- `sram_dq_oe` out 1: pad output enable.
- `sram_dq_i` in 16: read data from the pads.
- `sram_we_n`, `sram_oe_n`, `sram_lb_n`, `sram_ub_n` out 1 each: SRAM strobes.

## Operation
- States:
  - `IDLE`
  - `RD1`: address out, `oe_n` = 0.
  - `RD2`: `oe_n` = 0; `dq_i` is captured at the end of this state.
  - `WS`: write setup. Address and data are driven; `we_n` = 1.
  - `WP`: `we_n` = 0.
  - `WH`: `we_n` = 1; data is still driven.
- Read path: `IDLE` → `RD1` → `RD2` → `IDLE`.
- Write path: `IDLE` → `WS` → `WP` → `WH` → `IDLE`.
- Grant in `IDLE`, evaluated in priority order:
  1. A pending video request (`vid_req`, or a latched late request).
  2. `dbg_req`, if `dbg_hlda` = 1 and `vid_soon` = 0.
  3. `cpu_req`, if `dbg_hlda` = 0 and `vid_soon` = 0.
- The arbiter never grants a requester in the cycle its ack is high. That cycle is the requester's turn to drop its req.
- Byte lanes:
  - Writes: `lb_n` = ~`be[0]` and `ub_n` = ~`be[1]`.
  - Reads and debug writes: both lanes low.
  - Idle: both lanes high.
  - A CPU write with `be` = 00 still runs the full cycle, with no lane asserted.
- Hold handshake:
  - `dbg_hold` rising while the bus is in `IDLE`: `dbg_hlda` = 1 on the next cycle.
  - `dbg_hold` rising during a CPU access: the access completes, then `dbg_hlda` is set.
  - `dbg_hold` falling: `dbg_hlda` clears on the next cycle. An in-flight debug access completes first.
- Video arriving while the state machine is not `IDLE` (lead-window violation):
  - The request and its address are latched and served immediately after the current access.
  - `vid_late` is set and stays set until reset.
  - A second `vid_req` while one is already latched overwrites the latched one.
- Capture registers:
  - `cpu_rdata`, `dbg_rdata` and `vid_data` load only at the end of `RD2` for their own requester.
  - They hold their value otherwise.

## Timing
- Let t be the cycle in which a request is sampled in `IDLE`.
- Read: `RD1` = t+1, `RD2` = t+2. Ack or `vid_valid` = t+3, with data valid in the same cycle. The bus is back in `IDLE` at t+3.
- Write: `WS` = t+1, `WP` = t+2, `WH` = t+3. Ack = t+4, with the bus in `IDLE` at t+4.
- Video latency is exactly 3 cycles when `vid_soon` rose at least `VID_LEAD` cycles before `vid_req`.
- All SRAM pins are registered and change only on the `clk` edge.
- `sram_dq_oe` = 1 only in `WS`, `WP` and `WH`.
- Reset (asynchronous, can hit mid-access):
  - The access is aborted and the state returns to `IDLE`.
  - Strobes: `we_n` = `oe_n` = `lb_n` = `ub_n` = 1, `dq_oe` = 0, `sram_addr` = 0.
  - Handshake and flags: all acks = 0, `vid_valid` = 0, `dbg_hlda` = 0, `vid_late` = 0.
  - Data registers: `rdata`/`vid_data` = 0, and any latched video request is cleared.

## Structure
- Package `bk_mem_pkg`:
  - State enum.
  - Requester-ID enum (`RQ_NONE`, `RQ_VID`, `RQ_DBG`, `RQ_CPU`).
  - `VID_LEAD` default.
- One sub-module, `sram_io`: the pad-facing output registers and tristate control.
- Arbitration and the state machine stay in `sram_arbiter`.

## Test plan
- CPU read, addr 0x01234, SRAM model returns 0xBEEF → `oe_n` low at t+1..t+2; `cpu_ack` at t+3 with `cpu_rdata` = 0xBEEF.
- CPU byte write, `be` = 10, data 0xA55A → `ub_n` = 0, `lb_n` = 1, `we_n` low only at t+2, `dq_oe` high t+1..t+3, `cpu_ack` at t+4.
- `vid_soon` raised 3 cycles before `vid_req` while `cpu_req` is held → CPU is deferred; `vid_valid` exactly 3 cycles after `vid_req`; CPU is served afterwards; `vid_late` = 0.
- `vid_req` during a CPU write's `WP` with no lead → the write completes; the video read starts next; `vid_late` = 1.
- `dbg_hold` raised during a CPU read → `dbg_hlda` after that `cpu_ack`; a debug write of 0x1234 to 0x08000 completes; `cpu_req` is ignored until `dbg_hold` drops.
- `reset_n` pulsed low during `WP` → `we_n` = 1 and `dq_oe` = 0 immediately, no ack is issued, and the state is `IDLE` after release.
